// File: rtl/frame_seq_pkg.sv
// Shared types and constants for the per-shot frame sequencer.
package frame_seq_pkg;

    localparam int N_SUB = 8;
    localparam int SUB_W = 3;
    localparam int TO_W  = 16;

    localparam logic [N_SUB-1:0] MASK_ALL = 8'hFF;
    localparam logic [15:0]      OVR_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_STORE     = 3'd2,
        S_DAC_RST   = 3'd3,
        S_DAC_WAIT  = 3'd4,
        S_SUB_SYNC  = 3'd5,
        S_STARTED   = 3'd6,
        S_WAIT_DONE = 3'd7
    } state_t;

endpackage

// File: rtl/frame_seq_if.sv
// Control/status bundle between the frame sequencer and the datapath around it.
interface frame_seq_if;

    logic                             i_sync;
    logic [frame_seq_pkg::N_SUB-1:0]  i_sub_mask;
    logic [frame_seq_pkg::TO_W-1:0]   i_timeout;
    logic [1:0]                       i_param_done;
    logic                             i_dac_rdy;
    logic [1:0]                       i_done;

    logic                             o_load_param;
    logic                             o_sub_sync;
    logic [frame_seq_pkg::SUB_W-1:0]  o_sub_channel;
    logic                             o_dac_vld;
    logic                             o_busy;
    logic                             o_half;
    logic                             o_frame_irq;
    logic [31:0]                      o_packet_cnt;
    logic [15:0]                      o_overrun_cnt;
    logic                             o_timeout_err;

    modport slave (
        input  i_sync, i_sub_mask, i_timeout, i_param_done, i_dac_rdy, i_done,
        output o_load_param, o_sub_sync, o_sub_channel, o_dac_vld, o_busy,
               o_half, o_frame_irq, o_packet_cnt, o_overrun_cnt, o_timeout_err
    );

    modport master (
        output i_sync, i_sub_mask, i_timeout, i_param_done, i_dac_rdy, i_done,
        input  o_load_param, o_sub_sync, o_sub_channel, o_dac_vld, o_busy,
               o_half, o_frame_irq, o_packet_cnt, o_overrun_cnt, o_timeout_err
    );

endinterface

// File: rtl/frame_seq_next.sv
// Finds the lowest enabled sub-channel strictly above the current one,
// or the lowest enabled one overall when first_i is set.
module frame_seq_next #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] mask_i,
    input  logic [W-1:0] cur_i,
    input  logic         first_i,
    output logic [W-1:0] nxt_o,
    output logic         found_o
);

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        nxt_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i] && (first_i || (i > int'(cur_i)))) begin
                nxt_o   = W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_seq.sv
// Per-shot sequencer: walks enabled sub-channels on each sync and owns the
// packet/overrun counters, ping-pong half flag, frame IRQ and watchdog.
module frame_seq
    import frame_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    frame_seq_if.slave bus
);

    state_t             state_q;
    logic [N_SUB-1:0]   mask_q;
    logic [SUB_W-1:0]   ch_q;
    logic [TO_W-1:0]    wd_q;
    logic [31:0]        pkt_q;
    logic [15:0]        ovr_q;
    logic               half_q;
    logic               irq_q;
    logic               zpend_q;
    logic               terr_q;

    logic [N_SUB-1:0]   fnd_mask;
    logic [SUB_W-1:0]   fnd_ch;
    logic               fnd_ok;
    logic [TO_W-1:0]    wd_inc_d;
    logic               wd_run;
    logic               wd_fire;

    // A sync always searches the freshly presented mask from index 0.
    assign fnd_mask = bus.i_sync ? bus.i_sub_mask : mask_q;

    frame_seq_next #(.N(N_SUB), .W(SUB_W)) u_next (
        .mask_i  (fnd_mask),
        .cur_i   (ch_q),
        .first_i (bus.i_sync),
        .nxt_o   (fnd_ch),
        .found_o (fnd_ok)
    );

    assign wd_inc_d = wd_q + 1'b1;
    assign wd_run   = state_q inside {S_STORE, S_DAC_RST, S_DAC_WAIT, S_STARTED, S_WAIT_DONE};
    assign wd_fire  = wd_run && (bus.i_timeout != '0) && (wd_inc_d == bus.i_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            ch_q    <= '0;
            wd_q    <= '0;
            pkt_q   <= '0;
            ovr_q   <= '0;
            half_q  <= 1'b0;
            irq_q   <= 1'b0;
            zpend_q <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            irq_q   <= zpend_q;
            zpend_q <= 1'b0;
            wd_q    <= wd_run ? wd_inc_d : '0;
            if (bus.i_sync) begin
                mask_q <= bus.i_sub_mask;
                pkt_q  <= pkt_q + 32'd1;
                half_q <= ~half_q;
                terr_q <= 1'b0;
                wd_q   <= '0;
                irq_q  <= 1'b0;
                ch_q   <= fnd_ch;
                if ((state_q != S_IDLE) && (ovr_q != OVR_MAX)) begin
                    ovr_q <= ovr_q + 16'd1;
                end
                // An empty mask still produces a (delayed) frame-end IRQ.
                if (fnd_ok) begin
                    state_q <= S_LOAD;
                end else begin
                    state_q <= S_IDLE;
                    zpend_q <= 1'b1;
                end
            end else if (wd_fire) begin
                state_q <= S_IDLE;
                terr_q  <= 1'b1;
                irq_q   <= 1'b1;
                wd_q    <= '0;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        state_q <= S_STORE;
                        wd_q    <= '0;
                    end
                    S_STORE: if (&bus.i_param_done) begin
                        state_q <= S_DAC_RST;
                        wd_q    <= '0;
                    end
                    S_DAC_RST: if (bus.i_dac_rdy) begin
                        state_q <= S_DAC_WAIT;
                        wd_q    <= '0;
                    end
                    S_DAC_WAIT: if (bus.i_dac_rdy) begin
                        state_q <= S_SUB_SYNC;
                        wd_q    <= '0;
                    end
                    S_SUB_SYNC: begin
                        state_q <= S_STARTED;
                        wd_q    <= '0;
                    end
                    S_STARTED: if (bus.i_done == 2'b00) begin
                        state_q <= S_WAIT_DONE;
                        wd_q    <= '0;
                    end
                    S_WAIT_DONE: if (&bus.i_done) begin
                        wd_q <= '0;
                        if (fnd_ok) begin
                            ch_q    <= fnd_ch;
                            state_q <= S_LOAD;
                        end else begin
                            state_q <= S_IDLE;
                            irq_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_load_param  = (state_q == S_LOAD);
    assign bus.o_sub_sync    = (state_q == S_SUB_SYNC);
    assign bus.o_sub_channel = ch_q;
    assign bus.o_dac_vld     = (state_q != S_IDLE);
    assign bus.o_busy        = (state_q != S_IDLE);
    assign bus.o_half        = half_q;
    assign bus.o_frame_irq   = irq_q;
    assign bus.o_packet_cnt  = pkt_q;
    assign bus.o_overrun_cnt = ovr_q;
    assign bus.o_timeout_err = terr_q;

endmodule

// File: tb/tb_frame_seq.sv
// Directed bench for frame_seq: a sync-level model plus per-scenario literal checks.
module tb_frame_seq;

    logic clk;
    logic rst_n;
    int   cyc = 0;

    frame_seq_if bus ();

    frame_seq u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Sync-level model: counters follow the syncs the bench issued, the expected
    // sub-shot order is the enabled indices of the mask latched on the last sync.
    logic        hint_busy;
    logic [31:0] m_pkt;
    logic        m_half;
    logic [15:0] m_ovr;
    int          m_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pkt  <= '0;
            m_half <= 1'b0;
            m_ovr  <= '0;
            m_q.delete();
        end else if (bus.i_sync) begin
            m_pkt  <= m_pkt + 1;
            m_half <= ~m_half;
            if (hint_busy && m_ovr != 16'hFFFF) m_ovr <= m_ovr + 1;
            m_q.delete();
            for (int i = 0; i < 8; i++) if (bus.i_sub_mask[i]) m_q.push_back(i);
        end
    end

    int n_load, n_sub, n_irq, n_busy;
    int t_first_load, t_first_sub, t_sub_last, t_irq;

    always @(negedge clk) begin
        chk("packet_cnt", bus.o_packet_cnt, m_pkt);
        chk("half", 32'(bus.o_half), 32'(m_half));
        chk("overrun_cnt", 32'(bus.o_overrun_cnt), 32'(m_ovr));
        if (bus.o_busy) n_busy++;
        if (bus.o_load_param) begin
            if (n_load == 0) t_first_load = cyc;
            n_load++;
        end
        if (bus.o_sub_sync) begin
            if (n_sub == 0) t_first_sub = cyc;
            t_sub_last = cyc;
            n_sub++;
            if (m_q.size() == 0) chk("sub_unexpected", 32'(bus.o_sub_channel), 32'hFFFF_FFFF);
            else chk("sub_channel", 32'(bus.o_sub_channel), 32'(m_q.pop_front()));
        end
        if (bus.o_frame_irq) begin
            n_irq++;
            t_irq = cyc;
        end
    end

    // Environment: acquisition engines drop i_done on a sub-shot, return 3 cycles later.
    int stall_ch = -1;
    bit hold1    = 1'b0;

    initial begin
        int  tmr;
        bit  stalled;
        tmr     = 0;
        stalled = 1'b0;
        bus.i_done = 2'b11;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.i_done = 2'b11;
                tmr        = 0;
                stalled    = 1'b0;
            end else if (bus.o_sub_sync) begin
                bus.i_done = 2'b00;
                if (int'(bus.o_sub_channel) == stall_ch) stalled = 1'b1;
                else tmr = 3;
            end else if (stalled) begin
                if (stall_ch < 0) begin
                    stalled    = 1'b0;
                    bus.i_done = 2'b11;
                end
            end else if (tmr > 0) begin
                tmr--;
                if (tmr == 0) bus.i_done = hold1 ? 2'b01 : 2'b11;
            end
        end
    end

    task automatic clr_stats();
        n_load = 0; n_sub = 0; n_irq = 0; n_busy = 0;
        t_first_load = -1; t_first_sub = -1; t_sub_last = -1; t_irq = -1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        bus.i_sync = 1'b0;
        hint_busy  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clr_stats();
    endtask

    int t_sync;

    task automatic do_sync(input logic [7:0] mask, input bit busy);
        @(posedge clk);
        #1 bus.i_sync = 1'b1;
        bus.i_sub_mask = mask;
        hint_busy      = busy;
        t_sync         = cyc;
        @(posedge clk);
        #1 bus.i_sync = 1'b0;
        hint_busy     = 1'b0;
    endtask

    task automatic wait_irq(input string nm, input int budget);
        int start;
        start = n_irq;
        for (int k = 0; k < budget && n_irq == start; k++) @(posedge clk);
        chk(nm, 32'(n_irq > start), 32'd1);
        #1;
    endtask

    task automatic wait_sub(input string nm, input int n, input int budget);
        for (int k = 0; k < budget && n_sub < n; k++) @(posedge clk);
        chk(nm, 32'(n_sub >= n), 32'd1);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1, "time limit");
    end

    initial begin
        int irq_before;
        rst_n            = 1'b0;
        hint_busy        = 1'b0;
        bus.i_sync       = 1'b0;
        bus.i_sub_mask   = frame_seq_pkg::MASK_ALL;
        bus.i_timeout    = '0;
        bus.i_param_done = 2'b11;
        bus.i_dac_rdy    = 1'b1;
        clr_stats();

        // Reset state
        do_reset();
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_dac_vld", 32'(bus.o_dac_vld), 0);
        chk("rst_channel", 32'(bus.o_sub_channel), 0);
        chk("rst_packet", bus.o_packet_cnt, 0);
        chk("rst_terr", 32'(bus.o_timeout_err), 0);

        // Full mask; mask changes after the sync must not matter
        do_sync(8'hFF, 1'b0);
        bus.i_sub_mask = 8'h00;
        wait_irq("ff_irq", 300);
        repeat (3) @(posedge clk);
        #1;
        chk("ff_load_lat", 32'(t_first_load), 32'(t_sync + 1));
        chk("ff_sub_lat", 32'(t_first_sub), 32'(t_sync + 5));
        chk("ff_n_sub", 32'(n_sub), 8);
        chk("ff_n_load", 32'(n_load), 8);
        chk("ff_n_irq", 32'(n_irq), 1);
        chk("ff_packet", bus.o_packet_cnt, 1);
        chk("ff_half", 32'(bus.o_half), 1);
        chk("ff_busy_end", 32'(bus.o_busy), 0);

        // Sparse mask 0x21
        do_reset();
        do_sync(8'h21, 1'b0);
        wait_irq("m21_irq", 200);
        repeat (3) @(posedge clk);
        #1;
        chk("m21_n_load", 32'(n_load), 2);
        chk("m21_n_sub", 32'(n_sub), 2);
        chk("m21_n_irq", 32'(n_irq), 1);
        chk("m21_left", 32'(m_q.size()), 0);

        // Empty mask: no work, IRQ two cycles after the sync
        do_reset();
        do_sync(8'h00, 1'b0);
        wait_irq("m00_irq", 20);
        repeat (3) @(posedge clk);
        #1;
        chk("m00_irq_time", 32'(t_irq), 32'(t_sync + 2));
        chk("m00_n_irq", 32'(n_irq), 1);
        chk("m00_busy_cycles", 32'(n_busy), 0);
        chk("m00_n_load", 32'(n_load + n_sub), 0);

        // Overrun: second sync while waiting on channel 3
        do_reset();
        stall_ch = 3;
        do_sync(8'hFF, 1'b0);
        wait_sub("ovr_reach_ch3", 4, 200);
        repeat (4) @(posedge clk);
        do_sync(8'hFF, 1'b1);
        stall_ch = -1;
        chk("ovr_restart_ch", 32'(bus.o_sub_channel), 0);
        chk("ovr_restart_load", 32'(bus.o_load_param), 1);
        chk("ovr_cnt", 32'(bus.o_overrun_cnt), 1);
        chk("ovr_packet", bus.o_packet_cnt, 2);
        chk("ovr_half", 32'(bus.o_half), 0);
        wait_irq("ovr_irq", 300);
        repeat (2) @(posedge clk);
        #1;
        chk("ovr_n_irq", 32'(n_irq), 1);
        chk("ovr_n_sub", 32'(n_sub), 12);

        // Watchdog abort 100 cycles after entering WAIT_DONE
        do_reset();
        bus.i_timeout = 16'd100;
        hold1         = 1'b1;
        do_sync(8'h01, 1'b0);
        wait_irq("wd_irq", 400);
        chk("wd_irq_time", 32'(t_irq), 32'(t_sub_last + 102));
        chk("wd_terr", 32'(bus.o_timeout_err), 1);
        chk("wd_busy", 32'(bus.o_busy), 0);
        do_sync(8'h01, 1'b0);
        hold1 = 1'b0;
        chk("wd_terr_clr", 32'(bus.o_timeout_err), 0);
        wait_irq("wd_irq2", 200);
        chk("wd_terr_after", 32'(bus.o_timeout_err), 0);
        chk("wd_n_irq", 32'(n_irq), 2);
        bus.i_timeout = '0;

        // Overrun saturation: 0xFFFF+2 overrunning syncs, then async reset mid-frame
        do_reset();
        @(posedge clk);
        #1 bus.i_sync = 1'b1;
        bus.i_sub_mask = 8'hFF;
        hint_busy      = 1'b0;
        @(posedge clk);
        #1 hint_busy = 1'b1;
        repeat (65537) @(posedge clk);
        #1 bus.i_sync = 1'b0;
        hint_busy     = 1'b0;
        chk("sat_ovr", 32'(bus.o_overrun_cnt), 32'hFFFF);
        chk("sat_packet", bus.o_packet_cnt, 32'd65538);
        chk("sat_half", 32'(bus.o_half), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy", 32'(bus.o_busy), 1);
        irq_before = n_irq;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.o_busy), 0);
        chk("arst_dac_vld", 32'(bus.o_dac_vld), 0);
        chk("arst_strobes", 32'({bus.o_load_param, bus.o_sub_sync, bus.o_frame_irq}), 0);
        chk("arst_channel", 32'(bus.o_sub_channel), 0);
        chk("arst_half", 32'(bus.o_half), 0);
        chk("arst_packet", bus.o_packet_cnt, 0);
        chk("arst_ovr", 32'(bus.o_overrun_cnt), 0);
        chk("arst_terr", 32'(bus.o_timeout_err), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_no_irq", 32'(n_irq), 32'(irq_before));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
